wb_daq_mc_capture: RTL and testbench

- Parametrised successor to the single-channel DAQ capture path; one clock domain.
- Accepts sample streams from NUM_CHANNELS ADC front-ends and buffers each in a per-channel FIFO.
- Drains the FIFOs round-robin through a Wishbone B3 master into a per-channel region of system RAM (wb_ram0).
- Raises a level interrupt when every channel has stored the requested number of samples, or when a bus error aborts the capture.

---
 rtl/wb_daq_mc_capture.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_wb_daq_mc_capture.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_daq_mc_capture.sv
// Multi-channel DAQ capture engine.
//
// Per-channel sample FIFOs are drained round-robin through a Wishbone B3
// master. Each write targets the channel's region in system RAM, and every
// sample uses one 32-bit word. A level interrupt is raised when every channel
// has stored sample_count words, or when a bus error aborts the capture.
//
// Ports:
//   wb_clk, wb_rst_n      clock and synchronous active-low reset
//   enable                rising edge starts a capture; low stops it
//   base_addr             byte address of the channel 0 region
//   sample_count          samples to store per channel (latched at start)
//   sample_valid/_data    per-channel sample strobes and packed sample data
//   busy, interrupt       capture in progress / capture complete or aborted
//   bus_error, overflow   sticky status, cleared at the next capture start
//   wb_master_*           Wishbone B3 master (single write cycles only)
module wb_daq_mc_capture #(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned CH_STRIDE    = 1024
) (
    input  logic                           wb_clk,
    input  logic                           wb_rst_n,
    input  logic                           enable,
    input  logic [31:0]                    base_addr,
    input  logic [15:0]                    sample_count,
    input  logic [NUM_CHANNELS-1:0]        sample_valid,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] sample_data,
    output logic                           busy,
    output logic                           interrupt,
    output logic                           bus_error,
    output logic [NUM_CHANNELS-1:0]        overflow,
    output logic [31:0]                    wb_master_adr_o,
    output logic [31:0]                    wb_master_dat_o,
    output logic [3:0]                     wb_master_sel_o,
    output logic                           wb_master_we_o,
    output logic                           wb_master_cyc_o,
    output logic                           wb_master_stb_o,
    output logic [2:0]                     wb_master_cti_o,
    output logic [1:0]                     wb_master_bte_o,
    input  logic [31:0]                    wb_master_dat_i,
    input  logic                           wb_master_ack_i,
    input  logic                           wb_master_err_i,
    input  logic                           wb_master_rty_i
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    typedef enum logic [2:0] {StIdle, StArb, StWrite, StRetry, StDone} state_e;

    state_e state_q, state_d;

    logic                    enable_q;
    logic                    abort_q;
    logic [15:0]             count_q;
    logic [15:0]             stored_q   [NUM_CHANNELS];
    logic [15:0]             accepted_q [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0]   fifo_mem_q [NUM_CHANNELS][FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q   [NUM_CHANNELS];
    logic [PTR_W-1:0]        rd_ptr_q   [NUM_CHANNELS];
    logic [CNT_W-1:0]        fifo_cnt_q [NUM_CHANNELS];
    logic [CH_W-1:0]         last_q;
    logic [CH_W-1:0]         cur_ch_q;
    logic [31:0]             adr_q;
    logic [31:0]             dat_q;
    logic                    cyc_q;
    logic                    bus_error_q;
    logic [NUM_CHANNELS-1:0] overflow_q;

    logic                    start;
    logic                    flush;
    logic                    abort;
    logic                    busy_int;
    logic                    grant_valid;
    logic [CH_W-1:0]         grant_ch;
    logic                    pop_en;
    logic                    ack_take;
    logic                    err_take;
    logic                    rty_take;
    logic                    all_done;
    logic [NUM_CHANNELS-1:0] push;
    logic [NUM_CHANNELS-1:0] pop;
    logic [NUM_CHANNELS-1:0] ovf_hit;

    // Read data is never used by a write-only master.
    logic unused_dat;
    assign unused_dat = ^wb_master_dat_i;

    assign start    = (state_q == StIdle) && enable && !enable_q;
    // Abort is remembered so a brief re-raise of enable cannot cancel it.
    assign abort    = abort_q || !enable;
    assign err_take = (state_q == StWrite) && wb_master_err_i;
    assign ack_take = (state_q == StWrite) && wb_master_ack_i && !wb_master_err_i;
    assign rty_take = (state_q == StWrite) && wb_master_rty_i && !wb_master_ack_i &&
                      !wb_master_err_i;
    assign pop_en   = (state_q == StArb) && enable && grant_valid;
    assign flush    = (state_q != StIdle) && (state_d == StIdle);

    // Round-robin: first non-empty channel after the last granted one.
    always_comb begin
        logic [CH_W-1:0] idx;
        int unsigned     sum;
        grant_valid = 1'b0;
        grant_ch    = '0;
        idx         = '0;
        sum         = 0;
        for (int unsigned i = 1; i <= NUM_CHANNELS; i++) begin
            sum = (32'(last_q) + i) % NUM_CHANNELS;
            idx = CH_W'(sum);
            if (!grant_valid && (fifo_cnt_q[idx] != '0)) begin
                grant_valid = 1'b1;
                grant_ch    = idx;
            end
        end
    end

    // True when the ack being taken completes the last outstanding sample.
    always_comb begin
        logic [15:0] stored_next;
        all_done    = 1'b1;
        stored_next = '0;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            stored_next = stored_q[c];
            if (CH_W'(c) == cur_ch_q) begin
                stored_next = stored_q[c] + 16'd1;
            end
            if (stored_next != count_q) begin
                all_done = 1'b0;
            end
        end
    end

    // Sample intake; a full FIFO drops the sample even if it pops this cycle.
    always_comb begin
        logic valid_ok;
        logic full;
        push     = '0;
        pop      = '0;
        ovf_hit  = '0;
        valid_ok = 1'b0;
        full     = 1'b0;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            valid_ok   = busy_int && sample_valid[c] && (accepted_q[c] < count_q);
            full       = (fifo_cnt_q[c] == CNT_W'(FIFO_DEPTH));
            push[c]    = valid_ok && !full;
            ovf_hit[c] = valid_ok && full;
            pop[c]     = pop_en && (grant_ch == CH_W'(c));
        end
    end

    // FSM state register.
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (sample_count == 16'd0) ? StDone : StArb;
                end
            end
            StArb: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (grant_valid) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (err_take) begin
                    state_d = abort ? StIdle : StDone;
                end else if (ack_take) begin
                    if (abort) begin
                        state_d = StIdle;
                    end else begin
                        state_d = all_done ? StDone : StArb;
                    end
                end else if (rty_take) begin
                    state_d = abort ? StIdle : StRetry;
                end
            end
            StRetry: begin
                state_d = abort ? StIdle : StWrite;
            end
            StDone: begin
                if (!enable) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy_int  = (state_q == StArb) || (state_q == StWrite) || (state_q == StRetry);
        interrupt = (state_q == StDone);
    end

    // FIFO storage carries no reset; occupancy is tracked by the counters.
    always_ff @(posedge wb_clk) begin
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            if (push[c]) begin
                fifo_mem_q[c][wr_ptr_q[c]] <= sample_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Datapath, counters and bus registers.
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            enable_q    <= 1'b0;
            abort_q     <= 1'b0;
            count_q     <= '0;
            last_q      <= CH_W'(NUM_CHANNELS - 1);
            cur_ch_q    <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            cyc_q       <= 1'b0;
            bus_error_q <= 1'b0;
            overflow_q  <= '0;
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                stored_q[c]   <= '0;
                accepted_q[c] <= '0;
                wr_ptr_q[c]   <= '0;
                rd_ptr_q[c]   <= '0;
                fifo_cnt_q[c] <= '0;
            end
        end else begin
            enable_q <= enable;
            // cyc/stb follow the WRITE state one edge later, so RETRY idles a cycle.
            cyc_q    <= (state_d == StWrite);

            if ((state_q == StWrite) || (state_q == StRetry)) begin
                if (!enable) begin
                    abort_q <= 1'b1;
                end
            end else begin
                abort_q <= 1'b0;
            end

            if (pop_en) begin
                cur_ch_q <= grant_ch;
                last_q   <= grant_ch;
                adr_q    <= base_addr + (32'(grant_ch) * 32'(CH_STRIDE)) +
                            32'({stored_q[grant_ch], 2'b00});
                dat_q    <= 32'(fifo_mem_q[grant_ch][rd_ptr_q[grant_ch]]);
            end

            if (err_take) begin
                bus_error_q <= 1'b1;
            end

            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                if (start) begin
                    stored_q[c]   <= '0;
                    accepted_q[c] <= '0;
                    wr_ptr_q[c]   <= '0;
                    rd_ptr_q[c]   <= '0;
                    fifo_cnt_q[c] <= '0;
                end else if (flush) begin
                    wr_ptr_q[c]   <= '0;
                    rd_ptr_q[c]   <= '0;
                    fifo_cnt_q[c] <= '0;
                end else begin
                    if (push[c]) begin
                        wr_ptr_q[c]   <= wr_ptr_q[c] + 1'b1;
                        accepted_q[c] <= accepted_q[c] + 16'd1;
                    end
                    if (pop[c]) begin
                        rd_ptr_q[c] <= rd_ptr_q[c] + 1'b1;
                    end
                    if (push[c] && !pop[c]) begin
                        fifo_cnt_q[c] <= fifo_cnt_q[c] + 1'b1;
                    end else if (!push[c] && pop[c]) begin
                        fifo_cnt_q[c] <= fifo_cnt_q[c] - 1'b1;
                    end
                    if (ack_take && (cur_ch_q == CH_W'(c))) begin
                        stored_q[c] <= stored_q[c] + 16'd1;
                    end
                end
                if (ovf_hit[c]) begin
                    overflow_q[c] <= 1'b1;
                end
            end

            if (start) begin
                count_q     <= sample_count;
                bus_error_q <= 1'b0;
                overflow_q  <= '0;
            end
        end
    end

    assign busy            = busy_int;
    assign bus_error       = bus_error_q;
    assign overflow        = overflow_q;
    assign wb_master_adr_o = adr_q;
    assign wb_master_dat_o = dat_q;
    assign wb_master_sel_o = cyc_q ? 4'hF : 4'h0;
    assign wb_master_we_o  = cyc_q;
    assign wb_master_cyc_o = cyc_q;
    assign wb_master_stb_o = cyc_q;
    assign wb_master_cti_o = 3'b000;
    assign wb_master_bte_o = 2'b00;

endmodule

// File: tb/tb_wb_daq_mc_capture.sv
module tb_wb_daq_mc_capture;

    localparam int N  = 4;
    localparam int DW = 16;

    logic          wb_clk = 1'b0;
    logic          wb_rst_n;
    logic          enable;
    logic [31:0]   base_addr;
    logic [15:0]   sample_count;
    logic [N-1:0]  sample_valid;
    logic [N*DW-1:0] sample_data;
    logic          busy, interrupt, bus_error;
    logic [N-1:0]  overflow;
    logic [31:0]   adr, dat;
    logic [3:0]    sel;
    logic          we, cyc, stb;
    logic [2:0]    cti;
    logic [1:0]    bte;
    logic [31:0]   dat_i;
    logic          ack, err, rty;

    wb_daq_mc_capture #(
        .NUM_CHANNELS(N),
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (8),
        .CH_STRIDE   (1024)
    ) dut (
        .wb_clk         (wb_clk),
        .wb_rst_n       (wb_rst_n),
        .enable         (enable),
        .base_addr      (base_addr),
        .sample_count   (sample_count),
        .sample_valid   (sample_valid),
        .sample_data    (sample_data),
        .busy           (busy),
        .interrupt      (interrupt),
        .bus_error      (bus_error),
        .overflow       (overflow),
        .wb_master_adr_o(adr),
        .wb_master_dat_o(dat),
        .wb_master_sel_o(sel),
        .wb_master_we_o (we),
        .wb_master_cyc_o(cyc),
        .wb_master_stb_o(stb),
        .wb_master_cti_o(cti),
        .wb_master_bte_o(bte),
        .wb_master_dat_i(dat_i),
        .wb_master_ack_i(ack),
        .wb_master_err_i(err),
        .wb_master_rty_i(rty)
    );

    always #5 wb_clk = ~wb_clk;

    // Slave model: responds on the negedge so the DUT samples it at the next posedge.
    int          n_resp   = 0;
    int          rty_at   = -1;
    int          err_at   = -1;
    bit          hold     = 1'b0;
    int          neg_cnt  = 0;
    int          cyc_hi   = 0;
    bit          rty_pend = 1'b0;
    int          rty_neg  = 0;
    int          post_neg = 0;
    logic [31:0] rty_adr  = '0;
    logic [31:0] rty_dat  = '0;
    logic [31:0] post_adr = '0;
    logic [31:0] post_dat = '0;
    logic [31:0] log_adr[$];
    logic [31:0] log_dat[$];

    initial begin
        ack   = 1'b0;
        err   = 1'b0;
        rty   = 1'b0;
        dat_i = '0;
    end

    always @(negedge wb_clk) begin
        neg_cnt++;
        ack = 1'b0;
        err = 1'b0;
        rty = 1'b0;
        if (cyc && stb) begin
            cyc_hi++;
            if (!hold) begin
                if (n_resp == rty_at) begin
                    rty      = 1'b1;
                    rty_adr  = adr;
                    rty_dat  = dat;
                    rty_neg  = neg_cnt;
                    rty_pend = 1'b1;
                end else if (n_resp == err_at) begin
                    err = 1'b1;
                end else begin
                    ack = 1'b1;
                    log_adr.push_back(adr);
                    log_dat.push_back(dat);
                    if (rty_pend) begin
                        rty_pend = 1'b0;
                        post_neg = neg_cnt;
                        post_adr = adr;
                        post_dat = dat;
                    end
                end
                n_resp++;
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int lb;
    int snap;
    logic [31:0] q_adr[$];
    logic [31:0] q_dat[$];

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_irq(input int budget, input string tag);
        int k = 0;
        while (!interrupt && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(interrupt), 32'd1);
    endtask

    task automatic wait_cyc(input int budget, input string tag);
        int k = 0;
        while (!cyc && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(cyc), 32'd1);
    endtask

    task automatic collect(input int from, input logic [31:0] base, input int ch);
        q_adr.delete();
        q_dat.delete();
        for (int i = from; i < log_adr.size(); i++) begin
            if (((log_adr[i] - base) >> 10) == 32'(ch)) begin
                q_adr.push_back(log_adr[i]);
                q_dat.push_back(log_dat[i]);
            end
        end
    endtask

    initial begin
        wb_rst_n     = 1'b0;
        enable       = 1'b0;
        base_addr    = '0;
        sample_count = '0;
        sample_valid = '0;
        sample_data  = '0;
        repeat (3) tick();

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_irq", 32'(interrupt), 32'd0);
        check("rst_berr", 32'(bus_error), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_cyc", 32'(cyc), 32'd0);
        check("rst_stb", 32'(stb), 32'd0);
        check("rst_adr", adr, 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        wb_rst_n = 1'b1;
        tick();

        // Basic capture: 3 samples per channel, data 0xC0 + channel
        base_addr    = 32'h0;
        sample_count = 16'd3;
        lb           = log_adr.size();
        enable       = 1'b1;
        tick();
        check("basic_busy", 32'(busy), 32'd1);
        for (int n = 0; n < 12; n++) begin
            sample_valid = '0;
            sample_valid[n % N] = 1'b1;
            sample_data[(n % N)*DW +: DW] = 16'(16'hC0 + (n % N));
            tick();
        end
        sample_valid = '0;
        wait_irq(200, "basic_irq");
        check("basic_nwrites", 32'(log_adr.size() - lb), 32'd12);
        check("basic_busy_done", 32'(busy), 32'd0);
        check("basic_cyc_done", 32'(cyc), 32'd0);
        collect(lb, 32'h0, 2);
        check("basic_ch2_count", 32'(q_adr.size()), 32'd3);
        for (int j = 0; j < q_adr.size(); j++) begin
            check("basic_ch2_adr", q_adr[j], 32'h800 + 32'(j * 4));
            check("basic_ch2_dat", q_dat[j], 32'hC2);
        end
        enable = 1'b0;
        tick();
        check("basic_irq_clear", 32'(interrupt), 32'd0);

        // Round-robin fairness after a fresh reset (channel 0 first)
        wb_rst_n = 1'b0;
        tick();
        wb_rst_n     = 1'b1;
        tick();
        base_addr    = 32'h1000_0000;
        sample_count = 16'd8;
        lb           = log_adr.size();
        enable       = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            sample_valid = '1;
            for (int c = 0; c < N; c++) begin
                sample_data[c*DW +: DW] = 16'((c << 8) | k);
            end
            tick();
        end
        sample_valid = '0;
        wait_irq(300, "rr_irq");
        check("rr_nwrites", 32'(log_adr.size() - lb), 32'd32);
        for (int i = 0; i < 32 && (lb + i) < log_adr.size(); i++) begin
            check("rr_adr", log_adr[lb + i],
                  32'h1000_0000 + 32'((i % 4) * 1024) + 32'((i / 4) * 4));
            check("rr_dat", log_dat[lb + i], 32'(((i % 4) << 8) | (i / 4)));
        end
        check("rr_ovf", 32'(overflow), 32'd0);
        enable = 1'b0;
        tick();

        // Overflow: channel 1 floods while the slave stalls
        base_addr    = 32'h4000;
        sample_count = 16'd10;
        hold         = 1'b1;
        lb           = log_adr.size();
        enable       = 1'b1;
        tick();
        for (int k = 0; k < 12; k++) begin
            sample_valid    = 4'b0010;
            sample_data[DW +: DW] = 16'(16'h100 + k);
            tick();
        end
        sample_valid = '0;
        check("ovf_flag", 32'(overflow), 32'h2);
        check("ovf_hold_cyc", 32'(cyc), 32'd1);
        check("ovf_hold_stb", 32'(stb), 32'd1);
        check("ovf_hold_adr", adr, 32'h4400);
        check("ovf_hold_dat", dat, 32'h100);
        check("ovf_hold_sel", 32'(sel), 32'hF);
        check("ovf_hold_we", 32'(we), 32'd1);
        check("ovf_hold_nowr", 32'(log_adr.size() - lb), 32'd0);
        hold = 1'b0;
        repeat (30) tick();
        for (int r = 0; r < 10; r++) begin
            sample_valid = 4'b1101;
            if (r == 0) begin
                sample_valid[1] = 1'b1;
                sample_data[DW +: DW] = 16'h1FF;
            end
            for (int c = 0; c < N; c++) begin
                if (c != 1) sample_data[c*DW +: DW] = 16'(16'h200 + c * 16 + r);
            end
            tick();
            sample_valid = '0;
            repeat (5) tick();
        end
        wait_irq(400, "ovf_irq");
        check("ovf_nwrites", 32'(log_adr.size() - lb), 32'd40);
        collect(lb, 32'h4000, 1);
        check("ovf_ch1_count", 32'(q_adr.size()), 32'd10);
        for (int j = 0; j < q_adr.size(); j++) begin
            check("ovf_ch1_adr", q_adr[j], 32'h4400 + 32'(j * 4));
            check("ovf_ch1_dat", q_dat[j], (j < 9) ? 32'(32'h100 + j) : 32'h1FF);
        end
        check("ovf_flag_kept", 32'(overflow), 32'h2);
        check("ovf_berr", 32'(bus_error), 32'd0);
        enable = 1'b0;
        tick();

        // Retry on the first request, error on the 5th write
        base_addr    = 32'h8000;
        sample_count = 16'd2;
        rty_at       = n_resp;
        err_at       = n_resp + 5;
        lb           = log_adr.size();
        enable       = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            sample_valid = '1;
            for (int c = 0; c < N; c++) begin
                sample_data[c*DW +: DW] = 16'(16'hA00 + c * 16 + k);
            end
            tick();
        end
        sample_valid = '0;
        wait_irq(200, "err_irq");
        check("err_berr", 32'(bus_error), 32'd1);
        check("err_busy", 32'(busy), 32'd0);
        check("err_nwrites", 32'(log_adr.size() - lb), 32'd4);
        check("rty_same_adr", post_adr, rty_adr);
        check("rty_same_dat", post_dat, rty_dat);
        check("rty_gap", 32'(post_neg - rty_neg), 32'd2);
        snap = cyc_hi;
        repeat (20) tick();
        check("err_no_cyc", 32'(cyc_hi - snap), 32'd0);
        rty_at = -1;
        err_at = -1;
        enable = 1'b0;
        tick();

        // Abort: enable drops while a write is stalled
        base_addr    = 32'h0;
        sample_count = 16'd4;
        hold         = 1'b1;
        enable       = 1'b1;
        tick();
        sample_valid = 4'b0001;
        sample_data[0 +: DW] = 16'h55;
        tick();
        sample_valid = '0;
        wait_cyc(20, "abort_cyc_up");
        enable = 1'b0;
        repeat (3) tick();
        check("abort_busy_hold", 32'(busy), 32'd1);
        check("abort_cyc_hold", 32'(cyc), 32'd1);
        lb   = log_adr.size();
        hold = 1'b0;
        repeat (2) tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cyc", 32'(cyc), 32'd0);
        check("abort_nwrites", 32'(log_adr.size() - lb), 32'd1);
        repeat (5) tick();
        check("abort_irq", 32'(interrupt), 32'd0);

        // Reset in the middle of a stalled write
        sample_count = 16'd16;
        hold         = 1'b1;
        enable       = 1'b1;
        tick();
        sample_valid = 4'b0100;
        sample_data[2*DW +: DW] = 16'h77;
        tick();
        for (int k = 0; k < 9; k++) begin
            sample_valid = 4'b1000;
            sample_data[3*DW +: DW] = 16'h33;
            tick();
        end
        sample_valid = '0;
        wait_cyc(20, "mrst_cyc_up");
        check("mrst_ovf_pre", 32'(overflow), 32'h8);
        wb_rst_n = 1'b0;
        tick();
        check("mrst_cyc", 32'(cyc), 32'd0);
        check("mrst_stb", 32'(stb), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_ovf", 32'(overflow), 32'd0);
        check("mrst_adr", adr, 32'd0);
        check("mrst_dat", dat, 32'd0);
        check("mrst_irq", 32'(interrupt), 32'd0);
        hold     = 1'b0;
        enable   = 1'b0;
        wb_rst_n = 1'b1;
        tick();

        // Zero count: straight to DONE with no bus traffic
        sample_count = 16'd0;
        snap         = cyc_hi;
        enable       = 1'b1;
        tick();
        check("zero_irq", 32'(interrupt), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        repeat (10) tick();
        check("zero_no_cyc", 32'(cyc_hi - snap), 32'd0);
        enable = 1'b0;
        tick();
        check("zero_irq_clear", 32'(interrupt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
